seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 39 +++
 rtl/seq_alu_muldiv.sv | 119 +++++++++++
 rtl/seq_alu.sv | 172 +++++++++++++++++
 tb/tb_seq_alu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions
// and FSM state encoding.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_NOT = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b10001;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned engine: radix-2 shift-add multiply and, when
// SEQ_ALU_DIV_EN is defined, restoring divide; one bit per clock, W clocks.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     b_q, b_d;
  logic             accept;

  logic [W-1:0]     addend;
  logic [W:0]       mul_sum;
  logic [W-1:0]     mul_hi, mul_lo;

  assign addend  = lo_q[0] ? b_q : '0;
  assign mul_sum = {1'b0, hi_q} + {1'b0, addend};
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], lo_q[W-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic             op_q, op_d;
  logic [W:0]       shifted;
  logic             borrow;
  logic [W-1:0]     trial;
  logic [W-1:0]     div_hi, div_lo;

  // The partial remainder never exceeds the divisor, so the trial
  // difference fits in W bits whenever no borrow occurs.
  assign shifted = {hi_q, lo_q[W-1]};
  assign borrow  = shifted < {1'b0, b_q};
  assign trial   = shifted[W-1:0] - b_q;
  assign div_hi  = borrow ? shifted[W-1:0] : trial;
  assign div_lo  = {lo_q[W-2:0], ~borrow};
  assign accept  = start_i;
`else
  assign accept  = start_i && !op_i;
`endif

  always_comb begin
    run_d  = run_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
`ifdef SEQ_ALU_DIV_EN
    op_d   = op_q;
`endif
    if (accept) begin
      run_d = 1'b1;
      cnt_d = '0;
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
`ifdef SEQ_ALU_DIV_EN
      op_d  = op_i;
`endif
    end else if (run_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
`ifdef SEQ_ALU_DIV_EN
      hi_d = op_q ? div_hi : mul_hi;
      lo_d = op_q ? div_lo : mul_lo;
`else
      hi_d = mul_hi;
      lo_d = mul_lo;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
      op_q   <= 1'b0;
`endif
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
`ifdef SEQ_ALU_DIV_EN
      op_q   <= op_d;
`endif
    end
  end

  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential signed ALU with iterative MUL and optional DIV (macro
// SEQ_ALU_DIV_EN); every op spends at least one cycle in EXEC.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   alu_op,
  input  logic [W-1:0] operandA,
  input  logic [W-1:0] operandB,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] resultAccumulator,
  output logic [W-1:0] result_hi,
  output logic [3:0]   flags
);

  state_e       state_q, state_d;
  logic [4:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] res_q, res_d, hi_q, hi_d;
  logic [3:0]   flags_q, flags_d;

  logic         md_start, md_op, md_done, start_md, use_md;
  logic [W-1:0] md_a, md_b, md_hi, md_lo;

  logic [W:0]     add_w, sub_w;
  logic           add_ovf, sub_ovf;
  logic [2*W-1:0] mag_prod, prod;
  logic [W-1:0]   lr;
  logic           lc, lv, wr;

`ifdef SEQ_ALU_DIV_EN
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  logic [W-1:0] quo, rem;
  logic         div_ovf;

  // Quotient sign follows the operand signs; remainder follows the dividend.
  assign quo     = (a_q[W-1] ^ b_q[W-1]) ? -md_lo : md_lo;
  assign rem     = a_q[W-1] ? -md_hi : md_hi;
  assign div_ovf = (a_q == MIN_VAL) && (b_q == '1);
  assign start_md = (alu_op == OP_MUL) || ((alu_op == OP_DIV) && (operandB != '0));
  assign use_md   = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
`else
  assign start_md = (alu_op == OP_MUL);
  assign use_md   = (op_q == OP_MUL);
`endif

  assign md_start = (state_q == ST_IDLE) && start && start_md;
  assign md_op    = (alu_op == OP_DIV);
  assign md_a     = operandA[W-1] ? -operandA : operandA;
  assign md_b     = operandB[W-1] ? -operandB : operandB;

  seq_alu_muldiv #(.W(W), .CNT_W(CNT_W)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (md_a),
    .b_i     (md_b),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  assign add_w    = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w    = {1'b0, a_q} - {1'b0, b_q};
  assign add_ovf  = (a_q[W-1] == b_q[W-1]) && (add_w[W-1] != a_q[W-1]);
  assign sub_ovf  = (a_q[W-1] != b_q[W-1]) && (sub_w[W-1] != a_q[W-1]);
  assign mag_prod = {md_hi, md_lo};
  assign prod     = (a_q[W-1] ^ b_q[W-1]) ? -mag_prod : mag_prod;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    lr      = '0;
    lc      = 1'b0;
    lv      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = alu_op;
          a_d     = operandA;
          b_d     = operandB;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!use_md || md_done) begin
          state_d = ST_DONE;
          case (op_q)
            OP_ADD: begin lr = add_w[W-1:0]; lc = add_w[W]; lv = add_ovf; wr = 1'b1; end
            OP_SUB: begin lr = sub_w[W-1:0]; lc = sub_w[W]; lv = sub_ovf; wr = 1'b1; end
            OP_AND: begin lr = a_q & b_q; wr = 1'b1; end
            OP_OR:  begin lr = a_q | b_q; wr = 1'b1; end
            OP_XOR: begin lr = a_q ^ b_q; wr = 1'b1; end
            OP_NOT: begin lr = ~a_q; wr = 1'b1; end
            OP_SHL: begin lr = {a_q[W-2:0], 1'b0}; lc = a_q[W-1]; wr = 1'b1; end
            OP_SHR: begin lr = {a_q[W-1], a_q[W-1:1]}; lc = a_q[0]; wr = 1'b1; end
            OP_CMP: flags_d = pack_flags(sub_w[W-1:0] == '0, sub_w[W-1], sub_w[W], sub_ovf);
            OP_MUL: begin
              res_d   = prod[W-1:0];
              hi_d    = prod[2*W-1:W];
              flags_d = pack_flags(prod == '0, prod[2*W-1], 1'b0,
                                   prod[2*W-1:W] != {W{prod[W-1]}});
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
              if (b_q == '0) begin
                res_d   = '1;
                hi_d    = a_q;
                flags_d = pack_flags(1'b0, 1'b1, 1'b0, 1'b1);
              end else begin
                res_d   = quo;
                hi_d    = rem;
                flags_d = pack_flags(quo == '0, quo[W-1], 1'b0, div_ovf);
              end
            end
`else
            OP_DIV: flags_d = pack_flags(1'b0, 1'b0, 1'b0, 1'b1);
`endif
            default: ;
          endcase
          if (wr) begin
            res_d   = lr;
            hi_d    = '0;
            flags_d = pack_flags(lr == '0, lr[W-1], lc, lv);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign resultAccumulator = res_q;
  assign result_hi         = hi_q;
  assign flags             = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random ops
// compared against an integer-arithmetic reference model.
module tb_seq_alu;

  localparam int W = 16;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [4:0] T_ADD = 5'b00000, T_SUB = 5'b00001, T_AND = 5'b00010,
                         T_OR  = 5'b00011, T_XOR = 5'b00100, T_NOT = 5'b00101,
                         T_SHL = 5'b00110, T_SHR = 5'b00111, T_CMP = 5'b01110,
                         T_MUL = 5'b10000, T_DIV = 5'b10001;

  logic         clk, rst_n, start, busy, done;
  logic [4:0]   alu_op;
  logic [W-1:0] operandA, operandB, resultAccumulator, result_hi;
  logic [3:0]   flags;

  int checksRun    = 0;
  int checksPassed = 0;

  logic [W-1:0] expRes, expHi, nRes, nHi;
  logic [3:0]   expFlags, nFlags;
  int           nLat;

  seq_alu #(.W(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .alu_op            (alu_op),
    .operandA          (operandA),
    .operandB          (operandB),
    .busy              (busy),
    .done              (done),
    .resultAccumulator (resultAccumulator),
    .result_hi         (result_hi),
    .flags             (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksRun++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference model: plain signed/unsigned integer arithmetic on the operands.
  task automatic modelOp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub, r, q, rm;
    bit z, n, c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    nRes = expRes; nHi = expHi; nFlags = expFlags; nLat = 1;
    z = 0; n = 0; c = 0; v = 0;
    r = 0;
    case (op)
      T_ADD, T_SUB, T_CMP: begin
        if (op == T_ADD) begin r = sa + sb; c = (ua + ub) > 65535; end
        else begin r = sa - sb; c = ua < ub; end
        v = (r < -32768) || (r > 32767);
        z = (r[15:0] == 16'h0);
        n = r[15];
        if (op != T_CMP) begin nRes = r[15:0]; nHi = '0; end
        nFlags = {z, n, c, v};
      end
      T_AND, T_OR, T_XOR, T_NOT, T_SHL, T_SHR: begin
        case (op)
          T_AND: r = ua & ub;
          T_OR:  r = ua | ub;
          T_XOR: r = ua ^ ub;
          T_NOT: r = 65535 - ua;
          T_SHL: begin r = ua * 2; c = ua >= 32768; end
          default: begin r = sa >>> 1; c = ua[0]; end
        endcase
        nRes = r[15:0]; nHi = '0;
        nFlags = {nRes == 16'h0, nRes[15], c, 1'b0};
      end
      T_MUL: begin
        r = sa * sb;
        nRes = r[15:0]; nHi = r[31:16];
        nFlags = {r == 0, r < 0, 1'b0, (r < -32768) || (r > 32767)};
        nLat = W + 1;
      end
      T_DIV: begin
        if (!DIV_EN) nFlags = 4'b0001;
        else if (ub == 0) begin
          nRes = 16'hFFFF; nHi = a; nFlags = 4'b0101;
        end else if (sa == -32768 && sb == -1) begin
          nRes = 16'h8000; nHi = 16'h0000; nFlags = 4'b0101; nLat = W + 1;
        end else begin
          q = sa / sb; rm = sa % sb;
          nRes = q[15:0]; nHi = rm[15:0];
          nFlags = {q == 0, q < 0, 1'b0, 1'b0};
          nLat = W + 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    bit seen;
    modelOp(op, a, b);
    @(negedge clk);
    start = 1'b1; alu_op = op; operandA = a; operandB = b;
    @(posedge clk); #1;
    start = 1'b0;
    alu_op = 5'($urandom); operandA = W'($urandom); operandB = W'($urandom);
    checkOutput("busyAfterAccept", busy, 1);
    checkOutput("doneAfterAccept", done, 0);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1;
      else if (lat == 1 && nLat > 1)
        checkOutput("holdDuringExec", {result_hi, resultAccumulator}, {expHi, expRes});
    end
    checkOutput($sformatf("latency op=%05b", op), lat, nLat);
    checkOutput($sformatf("result op=%05b a=%0h b=%0h", op, a, b), resultAccumulator, nRes);
    checkOutput($sformatf("resultHi op=%05b a=%0h b=%0h", op, a, b), result_hi, nHi);
    checkOutput($sformatf("flags op=%05b a=%0h b=%0h", op, a, b), flags, nFlags);
    checkOutput("busyWithDone", busy, 1);
    expRes = nRes; expHi = nHi; expFlags = nFlags;
    @(posedge clk); #1;
    checkOutput("doneDropped", done, 0);
    checkOutput("busyDropped", busy, 0);
  endtask

  task automatic checkIgnoredStart();
    int edges, doneCount, doneEdge;
    modelOp(T_MUL, 16'hFED4, 16'd200);
    @(negedge clk);
    start = 1'b1; alu_op = T_MUL; operandA = 16'hFED4; operandB = 16'd200;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; doneCount = 0; doneEdge = 0;
    while (edges < 30) begin
      if (edges == 4) begin
        @(negedge clk);
        start = 1'b1; alu_op = T_ADD; operandA = 16'd1; operandB = 16'd1;
      end
      @(posedge clk); #1;
      edges++;
      if (edges == 5) start = 1'b0;
      if (done) begin doneCount++; doneEdge = edges; end
    end
    checkOutput("ignoredStartDoneCount", doneCount, 1);
    checkOutput("ignoredStartDoneEdge", doneEdge, W + 1);
    checkOutput("ignoredStartProduct", {result_hi, resultAccumulator}, {nHi, nRes});
    checkOutput("ignoredStartFlags", flags, nFlags);
    expRes = nRes; expHi = nHi; expFlags = nFlags;
  endtask

  task automatic checkResetAbort();
    int edges, doneCount;
    @(negedge clk);
    start = 1'b1; alu_op = DIV_EN ? T_DIV : T_MUL; operandA = 16'hFFF3; operandB = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortResult", resultAccumulator, 0);
    checkOutput("abortResultHi", result_hi, 0);
    checkOutput("abortFlags", flags, 0);
    expRes = '0; expHi = '0; expFlags = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    edges = 0; doneCount = 0;
    while (edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (done) doneCount++;
    end
    checkOutput("abortNoDone", doneCount, 0);
    applyStimulus(T_ADD, 16'd2, 16'd3);
    checkOutput("abortThenAdd", resultAccumulator, 16'd5);
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [4:0] opList [0:12];
    opList = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOT, T_SHL, T_SHR, T_CMP,
               T_MUL, T_DIV, 5'b01001, 5'b11111};
    rst_n = 1'b0; start = 1'b0; alu_op = '0; operandA = '0; operandB = '0;
    expRes = '0; expHi = '0; expFlags = '0;
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetOutputs", {result_hi, resultAccumulator}, 0);
    checkOutput("resetFlags", flags, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    applyStimulus(T_ADD, 16'd10, 16'd20);
    applyStimulus(T_CMP, 16'hFFE0, 16'd5);
    checkOutput("cmpFlagsSpec", flags, 4'b0100);
    checkOutput("cmpResultHeld", resultAccumulator, 16'd30);
    applyStimulus(T_ADD, 16'h7FFF, 16'h0001);
    checkOutput("addOvfResult", resultAccumulator, 16'h8000);
    checkOutput("addOvfFlags", flags, 4'b0101);
    applyStimulus(T_MUL, 16'hFED4, 16'd200);
    checkOutput("mulSpecProduct", {result_hi, resultAccumulator}, 32'hFFFF15A0);
    applyStimulus(T_DIV, 16'hFFF3, 16'd4);
    applyStimulus(T_DIV, 16'd7, 16'd0);
    applyStimulus(T_DIV, 16'h8000, 16'hFFFF);
    applyStimulus(T_SHL, 16'h8001, 16'd0);
    applyStimulus(T_SHR, 16'h8001, 16'd0);
    applyStimulus(5'b01001, 16'h1234, 16'h5678);

    checkIgnoredStart();
    checkResetAbort();

    for (int i = 0; i < 150; i++)
      applyStimulus(opList[$urandom_range(0, 12)], pickOperand(), pickOperand());

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
